key_led_ctrl: RTL
=================

Name: key_led_ctrl

Overview:
Multi-channel key-to-LED controller: the parametrised successor of the single key/LED path and free-running counter.
- Per channel: synchronises and debounces a raw active-low key and emits a one-cycle press pulse.
- Drives LEDs in one of four runtime-selected modes.
- Keeps a wrapping press counter.
- Sits between board push-buttons and the LED bank.

Parameters:
CH, 4, number of key/LED channels (>=1)
DB_CYCLES, 16, consecutive stable cycles required to accept a key level change (>=1)
BLINK_DIV, 8, clock cycles per blink/chase half-period (>=2)
CNT_W, 4, press counter width (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
key  input  CH  raw keys, asynchronous, 0 = pressed
mode  input  2  0 DIRECT, 1 TOGGLE, 2 BLINK, 3 CHASE; sampled every cycle
led  output  CH  LED drive, 1 = on, registered
press_pulse  output  CH  one-cycle strobe per accepted press, registered
press_cnt  output  CNT_W  total accepted presses modulo 2^CNT_W, registered

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low. While rst=0, all state is held at reset values.
- Reset values:
  - sync flops and key_db = all 1 (released).
  - debounce counters = 0; toggle state tog = 0.
  - blink divider = 0; blink phase = 0.
  - chase pointer = channel 0; chase direction = up.
  - led = 0, press_pulse = 0, press_cnt = 0.
- Synchroniser: 2-FF per channel. A key change set up before edge k is visible at sync output after edge k+1.
- Debounce, per channel:
  - Counter width $clog2(DB_CYCLES+1).
  - If sync == key_db, counter clears to 0.
  - Otherwise the counter increments. On the cycle it would reach DB_CYCLES, key_db takes the sync value and the counter clears.
  - Glitches shorter than DB_CYCLES cycles never reach key_db.
- press_pulse[i]: high for exactly one cycle, set on the same edge key_db[i] goes 1->0. No pulse on release.
- Press latency: key falls before edge k → key_db and press_pulse change at edge k+1+DB_CYCLES.
- tog[i] inverts on every press_pulse[i], in all modes, one edge after the pulse.
- Blink divider: counts 0..BLINK_DIV-1 and wraps. Blink phase inverts at each wrap, i.e. every BLINK_DIV cycles.
- led register, updated one edge after key_db/press_pulse/tog/phase:
  - DIRECT: led = ~key_db.
  - TOGGLE: led = tog.
  - BLINK: led = tog & {CH{phase}}.
  - CHASE: led = one-hot of the chase pointer.
- Chase pointer:
  - Advances only in mode 3, at each blink wrap: up = +1, down = -1, wrapping modulo CH.
  - Any press_pulse while in mode 3 inverts direction. A reversal and an advance in the same cycle use the new direction.
  - Pointer and direction are retained while in other modes. CH=1 keeps the pointer at 0.
- press_cnt:
  - Adds popcount(press_pulse) each cycle, modulo 2^CNT_W.
  - Simultaneous presses on several channels all count.
  - Value wraps silently from 2^CNT_W-1.
- Mode change: takes effect on led at the next edge. tog and press_cnt are unaffected.
- Reset mid-operation: all state clears immediately (asynchronous). No press_pulse is produced on reset release, even with keys held low. A key held through reset produces one press after DB_CYCLES+2 cycles.

Test Plan:
1. Glitch reject: CH=4, DB_CYCLES=4, clk period 100 ns, mode=0. Pulse key[0] low for 3 cycles → led stays 0, press_pulse stays 0, press_cnt=0.
2. Clean press, DB_CYCLES=4, mode=0: key[1] low before edge k →
   - press_pulse[1] high only during the cycle after edge k+5;
   - led=4'b0010 from edge k+6;
   - press_cnt=1.
   On release, led returns to 0 after the same latency, with no second pulse.
3. TOGGLE/BLINK, mode=1: press key[2] twice → led[2] goes 1, then 0. After a third press, switch to mode=2 → led[2] alternates every 8 cycles (BLINK_DIV=8).
4. CHASE, mode=3 from reset: led = 0001, 0010, 0100, 1000, 0001 at 8-cycle steps. Press key[3] while led=0100 → sequence reverses to 0010, 0001, 1000.
5. Counter wrap, CNT_W=4: press keys 0 and 2 simultaneously 8 times → press_cnt steps by 2 each time and reads 0 after the 8th.
6. Async reset: assert rst=0 mid-debounce with key[0] held low → all outputs 0 immediately. Release rst with key still low → exactly one press_pulse[0], DB_CYCLES+2 cycles later.

Source files
------------

// File: rtl/key_led_ctrl.sv
`timescale 1ns/1ps
// Multi-channel key-to-LED controller: per-channel synchroniser and debouncer,
// four runtime LED modes (direct, toggle, blink, chase) and a wrapping press counter.
module key_led_ctrl #(
  parameter int CH        = 4,
  parameter int DB_CYCLES = 16,
  parameter int BLINK_DIV = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    key,
  input  logic [1:0]       mode,
  output logic [CH-1:0]    led,
  output logic [CH-1:0]    press_pulse,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int DVW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PW  = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(BLINK_DIV - 1);
  localparam logic [PW-1:0]  PTR_LAST = PW'(CH - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_t;

  logic [CH-1:0]          sync1;
  logic [CH-1:0]          sync2;
  logic [CH-1:0]          key_db;
  logic [CH-1:0][DBW-1:0] db_cnt;
  logic [CH-1:0]          tog;
  logic [DVW-1:0]         div;
  logic                   phase;
  logic [PW-1:0]          ptr;
  logic                   dir_down;

  logic                   wrap;
  logic                   dir_next;
  logic [PW-1:0]          ptr_up;
  logic [PW-1:0]          ptr_dn;
  logic [CNT_W-1:0]       pulse_sum;
  logic [CH-1:0]          chase_led;

  // press_pulse is a one-cycle strobe with no back-pressure: a consumer
  // must sample it on every clock edge or lose the event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1       <= '1;
      sync2       <= '1;
      key_db      <= '1;
      db_cnt      <= '0;
      press_pulse <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      for (int i = 0; i < CH; i++) begin
        press_pulse[i] <= 1'b0;
        if (sync2[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          // Level accepted; a 1->0 change of key_db is a press.
          db_cnt[i]      <= '0;
          key_db[i]      <= sync2[i];
          press_pulse[i] <= key_db[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    wrap      = (div == DIV_LAST);
    dir_next  = dir_down ^ (|press_pulse);
    ptr_up    = (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
    ptr_dn    = (ptr == '0) ? PTR_LAST : ptr - PW'(1);
    chase_led = CH'(1) << ptr;
    pulse_sum = '0;
    for (int i = 0; i < CH; i++) begin
      pulse_sum = pulse_sum + CNT_W'(press_pulse[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tog       <= '0;
      div       <= '0;
      phase     <= 1'b0;
      ptr       <= '0;
      dir_down  <= 1'b0;
      led       <= '0;
      press_cnt <= '0;
    end else begin
      tog       <= tog ^ press_pulse;
      div       <= wrap ? '0 : div + DVW'(1);
      phase     <= phase ^ wrap;
      press_cnt <= press_cnt + pulse_sum;
      // Chase state only moves in chase mode; a reversal coinciding with
      // an advance steps in the new direction.
      if (mode_t'(mode) == MODE_CHASE) begin
        dir_down <= dir_next;
        if (wrap) begin
          ptr <= dir_next ? ptr_dn : ptr_up;
        end
      end
      case (mode_t'(mode))
        MODE_DIRECT: led <= ~key_db;
        MODE_TOGGLE: led <= tog;
        MODE_BLINK:  led <= tog & {CH{phase}};
        default:     led <= chase_led;
      endcase
    end
  end

endmodule
